// File: rtl/led_fade_pwm_pkg.sv
// Shared definitions for the LED fade PWM block.
// Holds the per-channel fade state encoding used by led_fade_channel.
package led_fade_pwm_pkg;

    // Channel fade states: resting OFF/ON, ramping RISE/FALL.
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RISE = 2'd1,
        ST_ON   = 2'd2,
        ST_FALL = 2'd3
    } fade_state_e;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: fade FSM, duty register and PWM comparator.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   tick        period boundary strobe (the cycle pwm_cnt wraps to 0)
//   tgt         desired LED state (1 = on)
//   pwm_cnt     shared PWM counter
//   enable      0 forces the LED output low
//   led         registered PWM drive
//   fading      1 while the channel is ramping (RISE or FALL)
module led_fade_channel
    import led_fade_pwm_pkg::*;
#(
    parameter int PWM_W     = 8,
    parameter int FADE_STEP = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             tgt,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             enable,
    output logic             led,
    output logic             fading
);

    localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] DUTY_MIN = {PWM_W{1'b0}};
    localparam logic [PWM_W:0]   STEP_EXT = (PWM_W + 1)'(FADE_STEP);

    // Saturating increment, computed one bit wider so the carry is visible.
    function automatic logic [PWM_W-1:0] sat_up(input logic [PWM_W-1:0] d);
        logic [PWM_W:0] sum;
        sum = {1'b0, d} + STEP_EXT;
        if (sum > {1'b0, DUTY_MAX}) begin
            sat_up = DUTY_MAX;
        end else begin
            sat_up = sum[PWM_W-1:0];
        end
    endfunction

    // Saturating decrement, clamps at zero instead of wrapping.
    function automatic logic [PWM_W-1:0] sat_dn(input logic [PWM_W-1:0] d);
        logic [PWM_W:0] diff;
        diff = {1'b0, d} - STEP_EXT;
        if ({1'b0, d} < STEP_EXT) begin
            sat_dn = DUTY_MIN;
        end else begin
            sat_dn = diff[PWM_W-1:0];
        end
    endfunction

    fade_state_e      state_r;
    fade_state_e      state_nxt_s;
    logic [PWM_W-1:0] duty_r;
    logic [PWM_W-1:0] duty_nxt_s;
    logic [PWM_W-1:0] duty_up_s;
    logic [PWM_W-1:0] duty_dn_s;
    logic             led_r;

    // Next-state and next-duty; only a period tick can move the channel.
    always_comb begin
        state_nxt_s = state_r;
        duty_nxt_s  = duty_r;
        duty_up_s   = sat_up(duty_r);
        duty_dn_s   = sat_dn(duty_r);
        if (tick) begin
            case (state_r)
                ST_OFF: begin
                    if (tgt) begin
                        state_nxt_s = ST_RISE;
                        duty_nxt_s  = duty_up_s;
                    end else begin
                        state_nxt_s = ST_OFF;
                        duty_nxt_s  = duty_r;
                    end
                end
                ST_RISE: begin
                    if (!tgt) begin
                        state_nxt_s = ST_FALL;
                        duty_nxt_s  = duty_dn_s;
                    end else if (duty_up_s == DUTY_MAX) begin
                        state_nxt_s = ST_ON;
                        duty_nxt_s  = duty_up_s;
                    end else begin
                        state_nxt_s = ST_RISE;
                        duty_nxt_s  = duty_up_s;
                    end
                end
                ST_ON: begin
                    if (!tgt) begin
                        state_nxt_s = ST_FALL;
                        duty_nxt_s  = duty_dn_s;
                    end else begin
                        state_nxt_s = ST_ON;
                        duty_nxt_s  = duty_r;
                    end
                end
                ST_FALL: begin
                    if (tgt) begin
                        state_nxt_s = ST_RISE;
                        duty_nxt_s  = duty_up_s;
                    end else if (duty_dn_s == DUTY_MIN) begin
                        state_nxt_s = ST_OFF;
                        duty_nxt_s  = duty_dn_s;
                    end else begin
                        state_nxt_s = ST_FALL;
                        duty_nxt_s  = duty_dn_s;
                    end
                end
                default: begin
                    state_nxt_s = ST_OFF;
                    duty_nxt_s  = DUTY_MIN;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            duty_nxt_s  = duty_r;
        end
    end

    // State and duty registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_OFF;
            duty_r  <= DUTY_MIN;
        end else begin
            state_r <= state_nxt_s;
            duty_r  <= duty_nxt_s;
        end
    end

    // PWM comparator; full duty is forced solid so the top code never drops out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= 1'b0;
        end else begin
            led_r <= enable && ((duty_r == DUTY_MAX) || (pwm_cnt < duty_r));
        end
    end

    assign led    = led_r;
    assign fading = (state_r == ST_RISE) || (state_r == ST_FALL);

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade stage: each count_in bit sets one LED's target and the LED
// ramps its PWM duty towards it instead of switching hard.
// Ports:
//   clk          system clock
//   rst_n        asynchronous reset, active low
//   enable       1 = run; 0 = hold fades, blank LEDs, restart PWM phase
//   count_in     counter value, bit i = target of LED i
//   led_out      registered PWM LED drive
//   period_tick  one-cycle pulse at each PWM period boundary
//   busy         1 while any channel is ramping
module led_fade_pwm
    import led_fade_pwm_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int PWM_W     = 8,
    parameter int PRESCALE  = 196,
    parameter int FADE_STEP = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] count_in,
    output logic [CNT_W-1:0] led_out,
    output logic             period_tick,
    output logic             busy
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};

    logic [PRE_W-1:0] pre_cnt_r;
    logic [PWM_W-1:0] pwm_cnt_r;
    logic [CNT_W-1:0] cnt_q_r;
    logic             period_tick_r;
    logic             busy_r;
    logic             step_s;
    logic             wrap_s;
    logic [CNT_W-1:0] led_s;
    logic [CNT_W-1:0] fading_s;

    assign step_s = enable && (pre_cnt_r == PRE_LAST);
    // Channels update on the wrap edge, so a new duty applies from pwm_cnt=0.
    assign wrap_s = step_s && (pwm_cnt_r == DUTY_MAX);

    // Prescaler: divides clk down to one PWM step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_r <= {PRE_W{1'b0}};
        end else if (!enable || (pre_cnt_r == PRE_LAST)) begin
            pre_cnt_r <= {PRE_W{1'b0}};
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
        end
    end

    // PWM counter, wraps naturally from DUTY_MAX to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_r <= {PWM_W{1'b0}};
        end else if (!enable) begin
            pwm_cnt_r <= {PWM_W{1'b0}};
        end else if (step_s) begin
            pwm_cnt_r <= pwm_cnt_r + PWM_W'(1);
        end else begin
            pwm_cnt_r <= pwm_cnt_r;
        end
    end

    // Input capture, period strobe and busy summary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q_r       <= {CNT_W{1'b0}};
            period_tick_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            cnt_q_r       <= count_in;
            period_tick_r <= wrap_s;
            busy_r        <= |fading_s;
        end
    end

    for (genvar g = 0; g < CNT_W; g++) begin : g_ch
        led_fade_channel #(
            .PWM_W     (PWM_W),
            .FADE_STEP (FADE_STEP)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (wrap_s),
            .tgt     (cnt_q_r[g]),
            .pwm_cnt (pwm_cnt_r),
            .enable  (enable),
            .led     (led_s[g]),
            .fading  (fading_s[g])
        );
    end

    assign led_out     = led_s;
    assign period_tick = period_tick_r;
    assign busy        = busy_r;

endmodule
